// File: rtl/match_tally.sv
// Saturating statistics on the sequence detector's ans stream: hit cycles,
// 0->1 events and longest run, with a valid/ack snapshot port for a reader.
module match_tally #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ans,
   input  logic             clear,
   input  logic             snap_req,
   input  logic             snap_ack,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] event_cnt,
   output logic [CNT_W-1:0] max_run,
   output logic             snap_valid,
   output logic [CNT_W-1:0] snap_event,
   output logic [CNT_W-1:0] snap_hit,
   output logic [CNT_W-1:0] snap_max
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } snap_state_t;

   snap_state_t      state, state_nxt;
   logic             snap_load;

   logic             prev_ans, prev_nxt;
   logic [CNT_W-1:0] cur_run, run_nxt;
   logic [CNT_W-1:0] hit_nxt, event_nxt, max_nxt;

   // Post-update values; the snapshot loads these so it matches the live
   // outputs after the capturing edge, clear included.
   always_comb begin
      hit_nxt   = hit_cnt;
      event_nxt = event_cnt;
      max_nxt   = max_run;
      run_nxt   = cur_run;
      prev_nxt  = prev_ans;
      if (clear) begin
         hit_nxt   = '0;
         event_nxt = '0;
         max_nxt   = '0;
         run_nxt   = '0;
         prev_nxt  = 1'b0;
      end else begin
         prev_nxt = ans;
         if (ans) begin
            if (hit_cnt != CNT_MAX) hit_nxt = hit_cnt + CNT_ONE;
            if (cur_run != CNT_MAX) run_nxt = cur_run + CNT_ONE;
            if (run_nxt > max_run) max_nxt = run_nxt;
            if (!prev_ans && (event_cnt != CNT_MAX)) event_nxt = event_cnt + CNT_ONE;
         end else begin
            run_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt   <= '0;
         event_cnt <= '0;
         max_run   <= '0;
         cur_run   <= '0;
         prev_ans  <= 1'b0;
      end else begin
         hit_cnt   <= hit_nxt;
         event_cnt <= event_nxt;
         max_run   <= max_nxt;
         cur_run   <= run_nxt;
         prev_ans  <= prev_nxt;
      end
   end

   // Handshake: snap_valid high means snap_* are stable and unacknowledged;
   // the reader pulses snap_ack to release them. Requests are only taken in
   // IDLE, so a request during the ack cycle is dropped and must be repeated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (snap_req) state_nxt = HOLD;
         HOLD:    if (snap_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      snap_valid = (state == HOLD);
      snap_load  = (state == IDLE) && snap_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_event <= '0;
         snap_hit   <= '0;
         snap_max   <= '0;
      end else if (snap_load) begin
         snap_event <= event_nxt;
         snap_hit   <= hit_nxt;
         snap_max   <= max_nxt;
      end
   end

endmodule

// File: tb/tb_match_tally.sv
// Bench for match_tally: directed scenarios plus a randomized run, checked
// against a history-based model evaluated at CNT_W=8 and CNT_W=3.
module tb_match_tally;

   logic clk = 1'b0;
   logic reset, ans, clear, snap_req, snap_ack;

   logic [7:0] h8, e8, m8, se8, sh8, sm8;
   logic       sv8;
   logic [2:0] h3, e3, m3, se3, sh3, sm3;
   logic       sv3;

   logic [23:0] live8_dut, snap8_dut;
   logic [8:0]  live3_dut, snap3_dut;
   logic [67:0] all_dut;

   assign live8_dut = {h8, e8, m8};
   assign snap8_dut = {sh8, se8, sm8};
   assign live3_dut = {h3, e3, m3};
   assign snap3_dut = {sh3, se3, sm3};
   assign all_dut   = {live8_dut, snap8_dut, sv8, live3_dut, snap3_dut, sv3};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   match_tally #(.CNT_W(8)) u_dut8 (
      .clk(clk), .reset(reset), .ans(ans), .clear(clear),
      .snap_req(snap_req), .snap_ack(snap_ack),
      .hit_cnt(h8), .event_cnt(e8), .max_run(m8), .snap_valid(sv8),
      .snap_event(se8), .snap_hit(sh8), .snap_max(sm8)
   );

   match_tally #(.CNT_W(3)) u_dut3 (
      .clk(clk), .reset(reset), .ans(ans), .clear(clear),
      .snap_req(snap_req), .snap_ack(snap_ack),
      .hit_cnt(h3), .event_cnt(e3), .max_run(m3), .snap_valid(sv3),
      .snap_event(se3), .snap_hit(sh3), .snap_max(sm3)
   );

   // Reference model: ans samples since the last clear/reset; statistics are
   // recounted from this history and clipped to the counter ceiling.
   int          hist[$];
   bit          sv_m;
   logic [23:0] snap8_m;
   logic [8:0]  snap3_m;

   function automatic int satw(int v, int w);
      int m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   function automatic int hits_m();
      int n = 0;
      foreach (hist[i]) n += hist[i];
      return n;
   endfunction

   function automatic int events_m();
      int n = 0;
      int p = 0;
      foreach (hist[i]) begin
         if (hist[i] == 1 && p == 0) n++;
         p = hist[i];
      end
      return n;
   endfunction

   function automatic int longest_m();
      int run = 0;
      int best = 0;
      foreach (hist[i]) begin
         run = hist[i] ? run + 1 : 0;
         if (run > best) best = run;
      end
      return best;
   endfunction

   function automatic logic [23:0] live8_m();
      return {8'(satw(hits_m(), 8)), 8'(satw(events_m(), 8)), 8'(satw(longest_m(), 8))};
   endfunction

   function automatic logic [8:0] live3_m();
      return {3'(satw(hits_m(), 3)), 3'(satw(events_m(), 3)), 3'(satw(longest_m(), 3))};
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input logic a, input logic c, input logic sr, input logic sa);
      ans = a; clear = c; snap_req = sr; snap_ack = sa;
      @(posedge clk);
      if (c) hist.delete();
      else   hist.push_back(int'(a));
      if (!sv_m && sr) begin
         sv_m    = 1'b1;
         snap8_m = live8_m();
         snap3_m = live3_m();
      end else if (sv_m && sa) begin
         sv_m = 1'b0;
      end
      @(negedge clk);
      ans = 1'b0; clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ans = 1'b0; clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hist.delete();
      sv_m = 1'b0; snap8_m = '0; snap3_m = '0;
      reset = 1'b0;
   endtask

   task automatic stream();
      logic [9:0] pat;
      pat = 10'b0110100111;
      for (int i = 9; i >= 0; i--) cycle(pat[i], 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      #2 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ans = 1'($urandom_range(0, 1)); snap_req = 1'($urandom_range(0, 1));
         #1;
         n_checks++;
         if (all_dut !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h required 0", all_dut);
         end
         @(negedge clk);
      end
      do_reset();
   endtask

   task automatic test_stream();
      do_reset();
      stream();
      n_checks++;
      if (live8_dut !== {8'd6, 8'd3, 8'd3}) begin
         n_fail++;
         $display("FAIL stream: hit/event/max=%h required 060303", live8_dut);
      end
   endtask

   task automatic test_first_edge();
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({h8, e8} !== {8'd1, 8'd1}) begin
         n_fail++;
         $display("FAIL first_edge: hit=%0d event=%0d required 1 1", h8, e8);
      end
   endtask

   task automatic test_snapshot();
      do_reset();
      stream();
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({sv8, snap8_dut} !== {1'b1, 8'd7, 8'd3, 8'd4}) begin
         n_fail++;
         $display("FAIL snap_capture: valid=%0b hit/event/max=%h required 1 070304", sv8, snap8_dut);
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({h8, sv8, snap8_dut} !== {8'd11, 1'b1, 8'd7, 8'd3, 8'd4}) begin
         n_fail++;
         $display("FAIL snap_frozen: hit=%0d valid=%0b snap=%h required 11 1 070304", h8, sv8, snap8_dut);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({sv8, snap8_dut} !== {1'b0, 8'd7, 8'd3, 8'd4}) begin
         n_fail++;
         $display("FAIL snap_ack: valid=%0b snap=%h required 0 070304", sv8, snap8_dut);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (sv8 !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_in_idle: valid=%0b required 0", sv8);
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({live8_dut, sv8, snap8_dut} !== {24'd0, 1'b1, 24'd0}) begin
         n_fail++;
         $display("FAIL clear_with_snap: live=%h valid=%0b snap=%h required 0 1 0", live8_dut, sv8, snap8_dut);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({h8, sv8, snap8_dut} !== {8'd2, 1'b0, 24'd0}) begin
         n_fail++;
         $display("FAIL req_in_ack_cycle: hit=%0d valid=%0b snap=%h required 2 0 0", h8, sv8, snap8_dut);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (live3_dut !== {3'd7, 3'd1, 3'd7}) begin
         n_fail++;
         $display("FAIL sat3_run: hit/event/max=%0d/%0d/%0d required 7/1/7", h3, e3, m3);
      end
      n_checks++;
      if (live8_dut !== {8'd10, 8'd1, 8'd10}) begin
         n_fail++;
         $display("FAIL sat8_run: hit/event/max=%0d/%0d/%0d required 10/1/10", h8, e8, m8);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (live3_dut !== {3'd7, 3'd2, 3'd7}) begin
         n_fail++;
         $display("FAIL sat3_event: hit/event/max=%0d/%0d/%0d required 7/2/7", h3, e3, m3);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      stream();
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (sv8 !== 1'b1 || h8 === 8'd0) begin
         n_fail++;
         $display("FAIL pre_reset_hold: valid=%0b hit=%0d required 1 nonzero", sv8, h8);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (all_dut !== '0) begin
         n_fail++;
         $display("FAIL async_reset: outputs=%h required 0", all_dut);
      end
      @(negedge clk);
      hist.delete();
      sv_m = 1'b0; snap8_m = '0; snap3_m = '0;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({live8_dut, live3_dut} !== {live8_m(), live3_m()}) begin
         n_fail++;
         $display("FAIL resume_after_reset: live8=%h live3=%h required %h %h",
                  live8_dut, live3_dut, live8_m(), live3_m());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 4) == 0));
         n_checks++;
         if ({live8_dut, live3_dut} !== {live8_m(), live3_m()}) begin
            n_fail++;
            $display("FAIL random_live @%0d: live8=%h live3=%h required %h %h",
                     i, live8_dut, live3_dut, live8_m(), live3_m());
         end
         n_checks++;
         if ({sv8, snap8_dut, sv3, snap3_dut} !== {sv_m, snap8_m, sv_m, snap3_m}) begin
            n_fail++;
            $display("FAIL random_snap @%0d: v8=%0b s8=%h v3=%0b s3=%h required %0b %h %h",
                     i, sv8, snap8_dut, sv3, snap3_dut, sv_m, snap8_m, snap3_m);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      ans = 1'b0; clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
      sv_m = 1'b0; snap8_m = '0; snap3_m = '0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_first_edge();
      test_snapshot();
      test_simultaneous();
      test_saturation();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
